// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, imem request/response, FIFO to hazard stage.
// Ports: clk/rst, imem_req_*, imem_rsp_*, stall, redirect_*, instr/instr_pc/instr_valid.
// Optional: define IFETCH_BYPASS_EN to forward a response straight to the
// outputs when the FIFO is empty (zero response-to-output latency).
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [31:0]   rpc_q, rpc_d;
  logic [31:0]   fpc_q  [DEPTH];
  logic [31:0]   fdat_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0] tgt;
  logic        empty, keep, byp;
  logic        take, pop, push, fire;
  logic [CW:0] used;

  assign tgt   = {redirect_pc[31:2], 2'b00};
  assign empty = (cnt_q == '0);
  assign keep  = imem_rsp_valid
              && (drop_q == '0)
              && !redirect_valid;

  always_comb begin
    instr       = NOP;
    instr_pc    = '0;
    instr_valid = 1'b0;
    byp         = 1'b0;
    if (!empty) begin
      instr       = fdat_q[rd_q];
      instr_pc    = fpc_q[rd_q];
      instr_valid = 1'b1;
    end
`ifdef IFETCH_BYPASS_EN
    else if (keep) begin
      instr       = imem_rsp_data;
      instr_pc    = rpc_q;
      instr_valid = 1'b1;
      byp         = 1'b1;
    end
`endif
  end

  // A flush during redirect frees every FIFO slot, and an entry consumed
  // this cycle frees its slot, so both count as available credit.
  assign take = instr_valid && !stall && !redirect_valid;
  assign pop  = take && !byp;
  assign push = keep && !(byp && take);
  assign used = {1'b0, out_q}
              + (redirect_valid ? '0 : {1'b0, cnt_q})
              - {{CW{1'b0}}, take};

  assign imem_req_valid = !rst && (used < LIM);
  assign imem_req_addr  = redirect_valid ? tgt : pc_q;
  assign fire = imem_req_valid && imem_req_ready;

  // rpc tracks the PC of the next response that will be kept: kept
  // responses are always a sequential run starting at the last target.
  always_comb begin
    pc_d   = pc_q;
    rpc_d  = rpc_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    drop_d = drop_q;
    out_d  = out_q + CW'(fire) - CW'(imem_rsp_valid);
    if (fire) begin
      pc_d = imem_req_addr + 32'd4;
    end else if (redirect_valid) begin
      pc_d = tgt;
    end
    if (redirect_valid) begin
      // Only pre-redirect requests are stale; a target request issued
      // this cycle is kept.
      drop_d = out_q - CW'(imem_rsp_valid);
      rpc_d  = tgt;
      cnt_d  = '0;
      rd_d   = '0;
      wr_d   = '0;
    end else begin
      if (imem_rsp_valid && drop_q != '0) begin
        drop_d = drop_q - CW'(1);
      end
      if (keep) begin
        rpc_d = rpc_q + 32'd4;
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q   <= RESET_PC;
      rpc_q  <= RESET_PC;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      rpc_q  <= rpc_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fpc_q[wr_q]  <= rpc_q;
      fdat_q[wr_q] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      a_no_overflow: assert (!(cnt_q == FULL && !pop));
    end
  end

endmodule
